// File: rtl/dal_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | dal_pkg : shared constants, types and helpers for the stage-6 accumulator
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package dal_pkg;

  localparam int WIDTH         = 16;
  localparam int INTERVAL_SIZE = 8;
  localparam int PARA          = 16;
  localparam int PARALLEL_SIZE = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } stage6_state_e;

  typedef logic [WIDTH-1:0]                    fp16_t;
  typedef logic [INTERVAL_SIZE-1:0][PARA-1:0]  lane_cnt_t;

  function automatic logic [PARA-1:0] sat_inc(input logic [PARA-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_stat_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | lane_stat_reg : one lane's histogram, max count, winning mode and the
// |                 alpha/_alpha/beta parameters of the current winner
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module lane_stat_reg
  import dal_pkg::*;
(
  input  logic                     CLK_i,
  input  logic                     RST_ni,
  input  logic                     clr_i,
  input  logic                     load_i,
  input  logic                     upd_i,
  input  lane_cnt_t                cnt_i,
  input  logic [PARA-1:0]          max_i,
  input  logic [INTERVAL_SIZE-1:0] mode_i,
  input  fp16_t                    alpha_i,
  input  fp16_t                    nalpha_i,
  input  fp16_t                    beta_i,
  output lane_cnt_t                cnt_o,
  output logic [PARA-1:0]          max_o,
  output logic [INTERVAL_SIZE-1:0] mode_o,
  output fp16_t                    alpha_o,
  output fp16_t                    nalpha_o,
  output fp16_t                    beta_o
);

  lane_cnt_t                cnt_q,    cnt_d;
  logic [PARA-1:0]          max_q,    max_d;
  logic [INTERVAL_SIZE-1:0] mode_q,   mode_d;
  fp16_t                    alpha_q,  alpha_d;
  fp16_t                    nalpha_q, nalpha_d;
  fp16_t                    beta_q,   beta_d;

  always_comb begin
    cnt_d    = cnt_q;
    max_d    = max_q;
    mode_d   = mode_q;
    alpha_d  = alpha_q;
    nalpha_d = nalpha_q;
    beta_d   = beta_q;
    if (clr_i) begin
      cnt_d    = '0;
      max_d    = '0;
      mode_d   = '0;
      alpha_d  = '0;
      nalpha_d = '0;
      beta_d   = '0;
    end else if (load_i) begin
      // Histogram always follows stage 5; the winner only moves on U_add,
      // since stage 5 zeroes max/mode when there is no new winner.
      cnt_d = cnt_i;
      if (upd_i) begin
        max_d    = max_i;
        mode_d   = mode_i;
        alpha_d  = alpha_i;
        nalpha_d = nalpha_i;
        beta_d   = beta_i;
      end
    end
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      cnt_q    <= '0;
      max_q    <= '0;
      mode_q   <= '0;
      alpha_q  <= '0;
      nalpha_q <= '0;
      beta_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      mode_q   <= mode_d;
      alpha_q  <= alpha_d;
      nalpha_q <= nalpha_d;
      beta_q   <= beta_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign max_o    = max_q;
  assign mode_o   = mode_q;
  assign alpha_o  = alpha_q;
  assign nalpha_o = nalpha_q;
  assign beta_o   = beta_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage6.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | pipe_stage6 : registered accumulation stage closing the stage-5 vote loop;
// |               optional stall counter under PIPE_STAGE6_PERF_EN
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module pipe_stage6
  import dal_pkg::*;
(
  input  logic                                        CLK_i,
  input  logic                                        RST_ni,
  input  logic                                        start_i,
  input  logic [PARA-1:0]                             J_size_i,
  input  logic                                        valid_i,
  output logic                                        ready_o,
  input  logic [PARALLEL_SIZE*INTERVAL_SIZE*PARA-1:0] interval_cnt_i,
  input  logic [PARALLEL_SIZE-1:0]                    U_add_i,
  input  logic [PARALLEL_SIZE*INTERVAL_SIZE-1:0]      mode_i,
  input  logic [PARALLEL_SIZE*PARA-1:0]               max_cnt_i,
  input  logic [PARALLEL_SIZE*WIDTH-1:0]              alpha_i,
  input  logic [PARALLEL_SIZE*WIDTH-1:0]              _alpha_i,
  input  logic [PARALLEL_SIZE*WIDTH-1:0]              beta_i,
  output logic [PARALLEL_SIZE*INTERVAL_SIZE*PARA-1:0] interval_cnt_o,
  output logic [PARALLEL_SIZE*PARA-1:0]               max_cnt_o,
  output logic [PARALLEL_SIZE*INTERVAL_SIZE-1:0]      mode_o,
  output logic [PARALLEL_SIZE*WIDTH-1:0]              alpha_o,
  output logic [PARALLEL_SIZE*WIDTH-1:0]              _alpha_o,
  output logic [PARALLEL_SIZE*WIDTH-1:0]              beta_o,
  output logic [PARA-1:0]                             step_o,
  output logic                                        done_o
`ifdef PIPE_STAGE6_PERF_EN
  ,
  output logic [PARA-1:0]                             perf_stall_o
`endif
);

  localparam int LANE_CNT_W = INTERVAL_SIZE * PARA;

  stage6_state_e   state_q, state_d;
  logic [PARA-1:0] step_q,  step_d;
  logic [PARA-1:0] jsize_q, jsize_d;
  logic [PARA-1:0] step_inc;
  logic            clr;
  logic            load;

  assign step_inc = step_q + 1'b1;

  // start_i wins over a same-cycle valid_i, from every state.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    jsize_d = jsize_q;
    clr     = 1'b0;
    load    = 1'b0;
    if (start_i) begin
      clr     = 1'b1;
      step_d  = '0;
      jsize_d = J_size_i;
      state_d = (J_size_i == '0) ? DONE : ACCUM;
    end else begin
      case (state_q)
        ACCUM: begin
          if (valid_i) begin
            load   = 1'b1;
            step_d = step_inc;
            if (step_inc == jsize_q) state_d = DONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      state_q <= IDLE;
      step_q  <= '0;
      jsize_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      jsize_q <= jsize_d;
    end
  end

  assign ready_o = (state_q == ACCUM);
  assign done_o  = (state_q == DONE);
  assign step_o  = step_q;

  for (genvar l = 0; l < PARALLEL_SIZE; l++) begin : g_lane
    lane_stat_reg u_lane (
      .CLK_i    (CLK_i),
      .RST_ni   (RST_ni),
      .clr_i    (clr),
      .load_i   (load),
      .upd_i    (U_add_i[l]),
      .cnt_i    (interval_cnt_i[l*LANE_CNT_W +: LANE_CNT_W]),
      .max_i    (max_cnt_i[l*PARA +: PARA]),
      .mode_i   (mode_i[l*INTERVAL_SIZE +: INTERVAL_SIZE]),
      .alpha_i  (alpha_i[l*WIDTH +: WIDTH]),
      .nalpha_i (_alpha_i[l*WIDTH +: WIDTH]),
      .beta_i   (beta_i[l*WIDTH +: WIDTH]),
      .cnt_o    (interval_cnt_o[l*LANE_CNT_W +: LANE_CNT_W]),
      .max_o    (max_cnt_o[l*PARA +: PARA]),
      .mode_o   (mode_o[l*INTERVAL_SIZE +: INTERVAL_SIZE]),
      .alpha_o  (alpha_o[l*WIDTH +: WIDTH]),
      .nalpha_o (_alpha_o[l*WIDTH +: WIDTH]),
      .beta_o   (beta_o[l*WIDTH +: WIDTH])
    );
  end

`ifdef PIPE_STAGE6_PERF_EN
  logic [PARA-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_i)                         stall_d = '0;
    else if (state_q == ACCUM && !valid_i) stall_d = sat_inc(stall_q);
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign perf_stall_o = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage6.sv
`default_nettype none
// Self-checking bench for pipe_stage6: behavioural model plus directed scenarios.
module tb_pipe_stage6;
  import dal_pkg::*;

  localparam int HW = PARALLEL_SIZE*INTERVAL_SIZE*PARA;
  localparam int MW = PARALLEL_SIZE*INTERVAL_SIZE;
  localparam int XW = PARALLEL_SIZE*PARA;
  localparam int FW = PARALLEL_SIZE*WIDTH;

  logic          CLK_i = 1'b0, RST_ni = 1'b0, start_i = 1'b0, valid_i = 1'b0;
  logic [PARA-1:0] J_size_i = '0;
  logic [HW-1:0] interval_cnt_i = '0;
  logic [PARALLEL_SIZE-1:0] U_add_i = '0;
  logic [MW-1:0] mode_i = '0;
  logic [XW-1:0] max_cnt_i = '0;
  logic [FW-1:0] alpha_i = '0, _alpha_i = '0, beta_i = '0;
  logic          ready_o, done_o;
  logic [HW-1:0] interval_cnt_o;
  logic [XW-1:0] max_cnt_o;
  logic [MW-1:0] mode_o;
  logic [FW-1:0] alpha_o, _alpha_o, beta_o;
  logic [PARA-1:0] step_o;
`ifdef PIPE_STAGE6_PERF_EN
  logic [PARA-1:0] perf_stall_o;
`endif

  pipe_stage6 dut (
    .CLK_i(CLK_i), .RST_ni(RST_ni), .start_i(start_i), .J_size_i(J_size_i),
    .valid_i(valid_i), .ready_o(ready_o), .interval_cnt_i(interval_cnt_i),
    .U_add_i(U_add_i), .mode_i(mode_i), .max_cnt_i(max_cnt_i),
    .alpha_i(alpha_i), ._alpha_i(_alpha_i), .beta_i(beta_i),
    .interval_cnt_o(interval_cnt_o), .max_cnt_o(max_cnt_o), .mode_o(mode_o),
    .alpha_o(alpha_o), ._alpha_o(_alpha_o), .beta_o(beta_o),
    .step_o(step_o), .done_o(done_o)
`ifdef PIPE_STAGE6_PERF_EN
    , .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 CLK_i = ~CLK_i;

  int checks = 0, failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // state: 0 idle, 1 accumulating, 2 done
  int              m_state;
  logic [PARA-1:0] m_step, m_j, m_stall;
  logic [PARA-1:0] m_hist [PARALLEL_SIZE][INTERVAL_SIZE];
  logic [PARA-1:0] m_max  [PARALLEL_SIZE];
  logic [INTERVAL_SIZE-1:0] m_mode [PARALLEL_SIZE];
  logic [WIDTH-1:0] m_a [PARALLEL_SIZE], m_na [PARALLEL_SIZE], m_b [PARALLEL_SIZE];

  always @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni || start_i) begin
      m_step  <= '0;
      m_stall <= '0;
      m_j     <= RST_ni ? J_size_i : '0;
      m_state <= !RST_ni ? 0 : ((J_size_i == 0) ? 2 : 1);
      for (int l = 0; l < PARALLEL_SIZE; l++) begin
        m_max[l] <= '0; m_mode[l] <= '0; m_a[l] <= '0; m_na[l] <= '0; m_b[l] <= '0;
        for (int i = 0; i < INTERVAL_SIZE; i++) m_hist[l][i] <= '0;
      end
    end else if (m_state == 1) begin
      if (valid_i) begin
        m_step <= m_step + 1'b1;
        if (int'(m_step) + 1 == int'(m_j)) m_state <= 2;
        for (int l = 0; l < PARALLEL_SIZE; l++) begin
          for (int i = 0; i < INTERVAL_SIZE; i++)
            m_hist[l][i] <= interval_cnt_i[(l*INTERVAL_SIZE+i)*PARA +: PARA];
          if (U_add_i[l]) begin
            m_max[l]  <= max_cnt_i[l*PARA +: PARA];
            m_mode[l] <= mode_i[l*INTERVAL_SIZE +: INTERVAL_SIZE];
            m_a[l]    <= alpha_i[l*WIDTH +: WIDTH];
            m_na[l]   <= _alpha_i[l*WIDTH +: WIDTH];
            m_b[l]    <= beta_i[l*WIDTH +: WIDTH];
          end
        end
      end else if (m_stall != {PARA{1'b1}}) begin
        m_stall <= m_stall + 1'b1;
      end
    end
  end

  logic [HW-1:0] e_hist;
  logic [XW-1:0] e_max;
  logic [MW-1:0] e_mode;
  logic [FW-1:0] e_a, e_na, e_b;

  always @(negedge CLK_i) begin
    if (chk_en) begin
      for (int l = 0; l < PARALLEL_SIZE; l++) begin
        for (int i = 0; i < INTERVAL_SIZE; i++)
          e_hist[(l*INTERVAL_SIZE+i)*PARA +: PARA] = m_hist[l][i];
        e_max[l*PARA +: PARA]                   = m_max[l];
        e_mode[l*INTERVAL_SIZE +: INTERVAL_SIZE] = m_mode[l];
        e_a[l*WIDTH +: WIDTH]  = m_a[l];
        e_na[l*WIDTH +: WIDTH] = m_na[l];
        e_b[l*WIDTH +: WIDTH]  = m_b[l];
      end
      chk("hist",   interval_cnt_o, e_hist);
      chk("max",    max_cnt_o, e_max);
      chk("mode",   mode_o, e_mode);
      chk("alpha",  alpha_o, e_a);
      chk("_alpha", _alpha_o, e_na);
      chk("beta",   beta_o, e_b);
      chk("step",   step_o, m_step);
      chk("ready",  ready_o, m_state == 1);
      chk("done",   done_o, m_state == 2);
`ifdef PIPE_STAGE6_PERF_EN
      chk("perf",   perf_stall_o, m_stall);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge CLK_i);
    @(negedge CLK_i);
    #1;
  endtask

  // Stage-5-like payload: lanes without U_add present zero max/mode.
  task automatic payload(input logic [PARALLEL_SIZE-1:0] ua);
    U_add_i = ua;
    for (int l = 0; l < PARALLEL_SIZE; l++) begin
      for (int i = 0; i < INTERVAL_SIZE; i++)
        interval_cnt_i[(l*INTERVAL_SIZE+i)*PARA +: PARA] = PARA'($urandom_range(1, 500));
      max_cnt_i[l*PARA +: PARA] = ua[l] ? PARA'($urandom_range(1, 1000)) : '0;
      mode_i[l*INTERVAL_SIZE +: INTERVAL_SIZE] =
        ua[l] ? (INTERVAL_SIZE'(1) << $urandom_range(0, INTERVAL_SIZE-1)) : '0;
      alpha_i[l*WIDTH +: WIDTH]  = WIDTH'($urandom);
      _alpha_i[l*WIDTH +: WIDTH] = WIDTH'($urandom);
      beta_i[l*WIDTH +: WIDTH]   = WIDTH'($urandom);
    end
  endtask

  task automatic do_start(input logic [PARA-1:0] j);
    start_i = 1'b1; J_size_i = j; valid_i = 1'b0;
    cyc();
    start_i = 1'b0;
  endtask

  logic [PARA-1:0] cap_max;
  logic [INTERVAL_SIZE-1:0] cap_mode;
  logic [WIDTH-1:0] cap_a;
  logic [HW-1:0] cap_hist;
  logic [1:0] vpat [6];

  initial begin
    @(negedge CLK_i); @(negedge CLK_i);
    #1 RST_ni = 1'b1;
    chk("rst_step",  step_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_done",  done_o, 0);
    chk("rst_mode",  mode_o, 0);
    chk("rst_hist",  interval_cnt_o, 0);
    chk_en = 1'b1;

    // Normal pass: lane0 U_add 1,0,1,0
    do_start(16'd4);
    for (int k = 0; k < 4; k++) begin
      valid_i = 1'b1;
      payload({1'($urandom_range(0, 1)), 1'(k % 2 == 0)});
      if (k == 0) begin mode_i[7:0] = 8'h04; alpha_i[15:0] = 16'h3C00; end
      if (k == 2) begin mode_i[7:0] = 8'h20; alpha_i[15:0] = 16'h4000; cap_max = max_cnt_i[15:0]; end
      if (k == 3) chk("pass_done_before", done_o, 0);
      cyc();
    end
    valid_i = 1'b0;
    chk("pass_mode0",  mode_o[7:0], 8'h20);
    chk("pass_alpha0", alpha_o[15:0], 16'h4000);
    chk("pass_max0",   max_cnt_o[15:0], cap_max);
    chk("pass_step",   step_o, 4);
    chk("pass_done",   done_o, 1);
    chk("model_mode0", m_mode[0], 8'h20);
    valid_i = 1'b1; payload(2'b11);
    cyc();
    valid_i = 1'b0;
    chk("done_hold_alpha0", alpha_o[15:0], 16'h4000);

    // No-update hold
    do_start(16'd3);
    valid_i = 1'b1; payload(2'b11);
    cap_mode = mode_i[7:0]; cap_a = alpha_i[15:0]; cap_max = max_cnt_i[15:0];
    cyc();
    payload(2'b00); cap_hist = interval_cnt_i;
    cyc();
    valid_i = 1'b0;
    chk("hold_mode0",  mode_o[7:0], cap_mode);
    chk("hold_alpha0", alpha_o[15:0], cap_a);
    chk("hold_max0",   max_cnt_o[15:0], cap_max);
    chk("hold_hist",   interval_cnt_o, cap_hist);

    // Stalls: valid 1,0,0,1,0,1 with J=3
    do_start(16'd3);
    vpat = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
    for (int k = 0; k < 6; k++) begin
      valid_i = vpat[k][0];
      payload(2'(($urandom_range(0, 3))));
      cyc();
      if (k == 4) chk("stall_done_early", done_o, 0);
    end
    valid_i = 1'b0;
    chk("stall_done", done_o, 1);
    chk("stall_step", step_o, 3);
`ifdef PIPE_STAGE6_PERF_EN
    chk("stall_perf", perf_stall_o, 3);
`endif

    // J_size = 0
    do_start(16'd0);
    chk("j0_done",  done_o, 1);
    chk("j0_ready", ready_o, 0);
    chk("j0_alpha", alpha_o, 0);
    valid_i = 1'b1; payload(2'b11);
    cyc();
    valid_i = 1'b0;
    chk("j0_step", step_o, 0);

    // Restart priority at step 2
    do_start(16'd5);
    for (int k = 0; k < 2; k++) begin valid_i = 1'b1; payload(2'b11); cyc(); end
    start_i = 1'b1; J_size_i = 16'd5; valid_i = 1'b1; payload(2'b11);
    cyc();
    start_i = 1'b0; valid_i = 1'b0;
    chk("rs_step",  step_o, 0);
    chk("rs_hist",  interval_cnt_o, 0);
    chk("rs_ready", ready_o, 1);
    chk("rs_done",  done_o, 0);

    // Asynchronous reset mid-pass at step 3
    do_start(16'd6);
    for (int k = 0; k < 3; k++) begin valid_i = 1'b1; payload(2'b11); cyc(); end
    valid_i = 1'b0;
    #2 RST_ni = 1'b0;
    #1;
    chk("ar_hist",  interval_cnt_o, 0);
    chk("ar_max",   max_cnt_o, 0);
    chk("ar_mode",  mode_o, 0);
    chk("ar_alpha", alpha_o, 0);
    chk("ar_beta",  beta_o, 0);
    chk("ar_step",  step_o, 0);
    chk("ar_ready", ready_o, 0);
    chk("ar_done",  done_o, 0);
    @(negedge CLK_i); #1 RST_ni = 1'b1;
    cyc(); cyc();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
